// File: rtl/mux_arb8.sv
// Eight-way round-robin arbiter driving the select of a shared 8:1 mux.
// One owner at a time, bounded tenure of MAX_HOLD cycles, registered outputs.
module mux_arb8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       valid,
    output logic [3:0] hold_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] s_inc;
    logic [7:0] req_others;
    logic [3:0] pick_idle;
    logic [3:0] pick_next;
    logic       owner_req;
    logic       tenure_left;

    // Returns {found, index} of the first set bit of r searching p, p+1, ... p+7 (mod 8).
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    assign s_inc       = s + 3'd1;
    assign req_others  = req & ~onehot(s);
    assign pick_idle   = rr_pick(req, ptr);
    assign pick_next   = rr_pick(req_others, s_inc);
    assign owner_req   = req[s];
    assign tenure_left = (hold_cnt < MAX_HOLD_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 8'h00;
            s        <= 3'd0;
            valid    <= 1'b0;
            hold_cnt <= 4'd0;
            ptr      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_idle[3]) begin
                        state    <= BUSY;
                        gnt      <= onehot(pick_idle[2:0]);
                        s        <= pick_idle[2:0];
                        valid    <= 1'b1;
                        hold_cnt <= 4'd1;
                    end else begin
                        gnt      <= 8'h00;
                        valid    <= 1'b0;
                        hold_cnt <= 4'd0;
                    end
                end
                BUSY: begin
                    if (owner_req && tenure_left) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end else begin
                        // Release or expiry: rotate priority past the owner, hand off without a bubble.
                        ptr <= s_inc;
                        if (pick_next[3]) begin
                            gnt      <= onehot(pick_next[2:0]);
                            s        <= pick_next[2:0];
                            hold_cnt <= 4'd1;
                        end else if (owner_req) begin
                            hold_cnt <= 4'd1;
                        end else begin
                            state    <= IDLE;
                            gnt      <= 8'h00;
                            valid    <= 1'b0;
                            hold_cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= 8'h00;
                    valid    <= 1'b0;
                    hold_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_arb8.md
MUX_ARB8 -- requirements
Module: mux_arb8

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive cycles one requester may own the mux while others wait (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  request vector; bit i = requester i wants mux input i routed to the shared output.
REQ-005 Port: gnt  output  8  one-hot grant vector; all-zero when no owner.
REQ-006 Port: s  output  3  select driven to the 8:1 mux (s input); equals index of gnt bit when valid.
REQ-007 Port: valid  output  1  high when gnt is non-zero (mux output belongs to a requester).
REQ-008 Port: hold_cnt  output  4  cycles the current owner has held the grant, 1..MAX_HOLD; 0 when idle.

Function
REQ-009 The block SHALL implement two states: IDLE (no owner) and BUSY (one owner); all outputs registered.
REQ-010 Round-robin pointer ptr (3 bits) SHALL define priority: search order ptr, ptr+1, ..., ptr+7, modulo 8 (7 wraps to 0).
REQ-011 IDLE, req==0: remain IDLE; gnt=0, valid=0, hold_cnt=0, s holds last value.
REQ-012 IDLE, req!=0: next edge -> BUSY; winner w = first set req bit in search order; gnt=1<<w, s=w, valid=1, hold_cnt=1.
REQ-013 BUSY, req[s]=1 and hold_cnt<MAX_HOLD: keep grant; hold_cnt increments by 1.
REQ-014 BUSY, req[s]=0 (release): next edge ptr=s+1 mod 8; if any req bit set, grant next winner from new ptr with no idle bubble (hold_cnt=1); else -> IDLE.
REQ-015 BUSY, req[s]=1 and hold_cnt==MAX_HOLD (tenure expiry): ptr=s+1 mod 8; search req excluding bit s; if another requester found, grant it (hold_cnt=1); else re-grant s with hold_cnt=1.
REQ-016 Request changes on non-owner bits SHALL never preempt the owner before release or expiry.
REQ-017 gnt SHALL be one-hot or zero in every cycle; gnt[s]==valid always.
REQ-018 Simultaneous release and new requests on the same edge SHALL resolve per REQ-014 using ptr updated from the released owner.
REQ-019 A requester SHALL receive a grant within 7*MAX_HOLD+1 cycles of continuously asserting req (starvation bound).

Reset
REQ-020 rst_n low SHALL immediately (asynchronously) force state=IDLE, gnt=0, s=0, valid=0, hold_cnt=0, ptr=0.
REQ-021 Reset mid-BUSY SHALL abort the grant with no completion cycle; after rst_n rises, first edge with req!=0 grants from ptr=0.
REQ-022 rst_n deassertion SHALL be effective on the first rising clk edge after release; no state changes while rst_n low.

Verification
REQ-023 Reset: rst_n=0 with req=8'hFF mid-grant -> gnt=0, s=0, valid=0, hold_cnt=0 without waiting for clk.
REQ-024 Single requester: req=8'b0000_0100 held 3 cycles then dropped (MAX_HOLD=4) -> gnt=8'h04, s=2, hold_cnt 1,2,3; then IDLE, valid=0, s stays 2.
REQ-025 Fair rotation: req=8'hFF held, MAX_HOLD=4 -> owners 0,1,...,7,0 each for exactly 4 cycles, s 7->0 wrap, no idle cycle.
REQ-026 Expiry with lone requester: req=8'h80 held 10 cycles -> s=7 throughout, hold_cnt 1,2,3,4,1,2,3,4,1,2.
REQ-027 Back-to-back handoff: owner 3 releases while req=8'b0000_0011 -> next edge grant 0 (ptr=4 wraps), gnt=8'h01, hold_cnt=1, valid stays 1.
REQ-028 Non-preemption: owner 5 holding, req[1] rises -> gnt stays 8'h20 until release or hold_cnt==MAX_HOLD, then gnt=8'h02.
